// File: rtl/priority_mux_arbiter.sv
// Six-way arbiter driving the select of a shared 6:1 priority mux.
// Grants one requester for a burst of beats, then re-arbitrates.
module priority_mux_arbiter #(
    parameter int MAX_BURST = 4,
    parameter int PRIO_MODE = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] req,
    input  logic       out_ready,
    output logic [5:0] gnt,
    output logic [4:0] sel,
    output logic       out_valid,
    output logic [5:0] ack
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] LAST = CW'(MAX_BURST - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t        state;
    logic [2:0]    owner;
    logic [2:0]    rr_ptr;
    logic [CW-1:0] beat_cnt;

    logic [2:0]    win_idx;
    logic          win_any;
    logic [5:0]    win_gnt;
    logic [2:0]    cand;
    logic          accept;
    logic          rel;

    // Winner search: the last hit in scan order wins, so the scan runs
    // from lowest to highest priority.
    always_comb begin
        win_idx = '0;
        win_any = 1'b0;
        cand    = '0;
        if (PRIO_MODE != 0) begin
            for (int i = 0; i < 6; i++) begin
                if (req[3'(i)]) begin
                    win_idx = 3'(i);
                    win_any = 1'b1;
                end
            end
        end else begin
            for (int i = 6; i >= 1; i--) begin
                cand = 3'((int'(rr_ptr) + i) % 6);
                if (req[cand]) begin
                    win_idx = cand;
                    win_any = 1'b1;
                end
            end
        end
    end

    assign win_gnt = 6'b000001 << win_idx;

    // Beat handshake and release conditions.
    always_comb begin
        out_valid = (state == GRANT) && req[owner];
        accept    = out_valid && out_ready;
        ack       = gnt & {6{accept}};
        rel       = (state == GRANT) &&
                    (!req[owner] || (accept && beat_cnt == LAST));
    end

    // Grant state: load a new owner on idle-arbitration or release,
    // otherwise count accepted beats of the current burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= '0;
            sel      <= '0;
            beat_cnt <= '0;
            rr_ptr   <= 3'd5;
            owner    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (win_any) begin
                        state    <= GRANT;
                        gnt      <= win_gnt;
                        sel      <= win_gnt[5:1];
                        owner    <= win_idx;
                        rr_ptr   <= win_idx;
                        beat_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (rel && win_any) begin
                        gnt      <= win_gnt;
                        sel      <= win_gnt[5:1];
                        owner    <= win_idx;
                        rr_ptr   <= win_idx;
                        beat_cnt <= '0;
                    end else if (rel) begin
                        state    <= IDLE;
                        gnt      <= '0;
                        sel      <= '0;
                        beat_cnt <= '0;
                    end else if (accept) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
